fifo_burst_drain: RTL and testbench
===================================

# fifo_burst_drain

Read-side consumer for the CDC write-path FIFO in the SDRAM clock domain. It pops words from a first-word-fall-through FIFO read port and packs them into a local burst buffer of up to BLEN words. It then issues one write command per burst to the SDRAM controller and streams the buffered words out as the controller pulls them. Destination addresses advance linearly through a circular region [base_addr, limit_addr).

## Interface
- DWIDTH, 16: data word width; must match the FIFO.
- AWIDTH, 22: SDRAM word-address width.
- BLEN, 8: maximum burst length in words. Power of 2, range 2..256.
- FLUSH_CYCLES, 256: number of consecutive empty-FIFO cycles that force a partial burst out. Must be ≥1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- enable  in  1  run control.
- base_addr  in  AWIDTH  region start. Multiple of BLEN. Must be stable while enable=1.
- limit_addr  in  AWIDTH  region end, exclusive. Multiple of BLEN; must be > base_addr.
- fifo_rd_data  in  DWIDTH  FIFO head word; valid whenever fifo_empty=0.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_enable  out  1  pop strobe. Combinational; never asserted while fifo_empty=1.
- cmd_valid  out  1  write command valid.
- cmd_ready  in  1  controller accepts the command.
- cmd_addr  out  AWIDTH  burst start address.
- cmd_len  out  $clog2(BLEN)+1  words in the burst, range 1..BLEN.
- wr_data  out  DWIDTH  current burst word.
- wr_data_req  in  1  controller consumes wr_data this cycle.
- busy  out  1  high in every state except IDLE.

## Operation
- The FSM has four states: IDLE, FILL, CMD, DATA.
- **IDLE**
  - If enable=1: load addr←base_addr, cnt←0, go to FILL.
- **FILL**
  - fifo_rd_enable = !fifo_empty && cnt<BLEN.
  - On each pop: buf[cnt]←fifo_rd_data, cnt←cnt+1, clear the idle counter.
  - Idle counter increments each cycle where fifo_empty=1 and cnt>0; it is held at 0 while cnt=0.
  - Go to CMD when any of the following holds:
    - the pop that makes cnt=BLEN occurs;
    - the idle counter reaches FLUSH_CYCLES;
    - enable=0 and cnt>0.
  - Go to IDLE when enable=0 and cnt=0.
- **CMD**
  - cmd_valid=1, cmd_addr=addr, cmd_len=cnt. All three are held stable until the handshake.
  - On cmd_valid && cmd_ready: rptr←0, go to DATA.
- **DATA**
  - wr_data=buf[rptr]. On wr_data_req: rptr←rptr+1.
  - On the request that consumes the last word (rptr=cnt-1):
    - addr←addr+BLEN, or base_addr if addr+BLEN ≥ limit_addr;
    - cnt←0;
    - go to FILL if enable=1, else IDLE.
  - wr_data_req outside DATA is ignored.
- Every burst consumes one BLEN slot of address space, including partial bursts; unwritten words of the slot are left untouched.
- Address arithmetic is done in AWIDTH+1 bits to detect the limit without overflow.
- Deasserting enable never drops data. Buffered words are always flushed before IDLE; no FIFO pops occur after enable=0 is sampled.

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE; addr, cnt, rptr and the idle counter all 0.
  - Buffer contents are don't-care.
- Pop-to-capture: a word is registered at the clk edge where fifo_rd_enable=1. Sustained throughput is 1 pop/cycle.
- cmd_valid rises the cycle after the BLEN-th pop, or the cycle after the idle counter reaches FLUSH_CYCLES.
- wr_data is valid combinationally from the first DATA cycle and advances the cycle after each wr_data_req. After the last word is consumed, the block is in FILL on the next cycle.
- rst_n asserted mid-operation aborts immediately. Popped but unwritten words are lost, and no command or data is emitted afterward until re-enabled. The next start is at base_addr.

## Structure
- Shared package sdram_wr_pkg holds:
  - state encoding constants (IDLE, FILL, CMD, DATA);
  - a clog2 constant function;
  - burst-length width derivation, also used by the SDRAM controller command port.
- Sub-module burst_buffer: BLEN×DWIDTH register array with one synchronous write port (wr_en, wr_idx, wr_data) and one combinational read port (rd_idx).
- The FSM, counters and address generator stay in fifo_burst_drain.

## Test plan
- **Reset:** hold rst_n=0 with fifo_empty=0 and enable=1.
  - All outputs stay 0; fifo_rd_enable=0.
- **Full burst:** BLEN=8, base 0x100, limit 0x120; FIFO holds 0xA0..0xA7.
  - 8 consecutive pops.
  - cmd_valid rises the cycle after the 8th pop with cmd_addr=0x100, cmd_len=8.
  - With cmd_ready low for 5 cycles, the command stays stable.
  - wr_data_req on alternate cycles yields 0xA0..0xA7 in order.
- **Wrap:** 40 words, continuous.
  - cmd_addr sequence is 0x100, 0x108, 0x110, 0x118, 0x100.
- **Partial flush:** FLUSH_CYCLES=16; 3 words, then the FIFO stays empty.
  - cmd_valid rises 17 cycles after the last pop with cmd_len=3, cmd_addr=0x100.
  - The next burst is at 0x108.
- **Enable drop:** drop enable after 5 pops.
  - CMD is issued next cycle with cmd_len=5.
  - After 5 wr_data_req the block returns to IDLE, busy=0, and fifo_rd_enable stays 0 while fifo_empty=0.
- **Reset mid-DATA:** after 3 of 8 wr_data_req, pulse rst_n low.
  - Outputs go to 0 asynchronously.
  - Re-enabling gives a first cmd_addr of 0x100.

Source files
------------

// File: rtl/sdram_wr_pkg.sv
// Shared definitions for the SDRAM write path: drain FSM states and the
// width helpers also used by the SDRAM controller command port.
package sdram_wr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        CMD  = 2'd2,
        DATA = 2'd3
    } drain_state_t;

    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    // A burst length field must be able to hold BLEN itself, not just BLEN-1
    function automatic int blen_width(input int blen);
        return clog2(blen) + 1;
    endfunction

endpackage

// File: rtl/burst_buffer.sv
// BLEN-deep word store for one burst: synchronous write, combinational read.
module burst_buffer
    import sdram_wr_pkg::*;
#(
    parameter int DWIDTH = 16,
    parameter int BLEN   = 8,
    localparam int IXW   = clog2(BLEN)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [IXW-1:0]    wr_idx,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic [IXW-1:0]    rd_idx,
    output logic [DWIDTH-1:0] rd_data
);

    logic [DWIDTH-1:0] mem [BLEN];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/fifo_burst_drain.sv
// Drains a first-word-fall-through FIFO into SDRAM write bursts of up to
// BLEN words, walking destination addresses around [base_addr, limit_addr).
module fifo_burst_drain
    import sdram_wr_pkg::*;
#(
    parameter int DWIDTH       = 16,
    parameter int AWIDTH       = 22,
    parameter int BLEN         = 8,
    parameter int FLUSH_CYCLES = 256
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic [AWIDTH-1:0]           base_addr,
    input  logic [AWIDTH-1:0]           limit_addr,
    input  logic [DWIDTH-1:0]           fifo_rd_data,
    input  logic                        fifo_empty,
    output logic                        fifo_rd_enable,
    output logic                        cmd_valid,
    input  logic                        cmd_ready,
    output logic [AWIDTH-1:0]           cmd_addr,
    output logic [blen_width(BLEN)-1:0] cmd_len,
    output logic [DWIDTH-1:0]           wr_data,
    input  logic                        wr_data_req,
    output logic                        busy
);

    localparam int LW  = blen_width(BLEN);
    localparam int IXW = clog2(BLEN);
    localparam int IW  = clog2(FLUSH_CYCLES + 1);
    localparam int AW1 = AWIDTH + 1;

    localparam logic [LW-1:0]  BLEN_L     = LW'(BLEN);
    localparam logic [LW-1:0]  LAST_SLOT  = LW'(BLEN - 1);
    localparam logic [LW-1:0]  ONE_L      = LW'(1);
    localparam logic [IW-1:0]  FLUSH_LAST = IW'(FLUSH_CYCLES - 1);
    localparam logic [AW1-1:0] BLEN_A     = AW1'(BLEN);

    drain_state_t state, state_next;

    logic [AWIDTH-1:0] addr;
    logic [LW-1:0]     cnt;
    logic [IXW-1:0]    rptr;
    logic [IW-1:0]     idle_cnt;
    logic [AW1-1:0]    addr_sum;
    logic [DWIDTH-1:0] buf_rd_data;
    logic              pop;
    logic              idle_tick;
    logic              last_word;

    // One extra bit so a region ending at the top of the address space still wraps
    assign addr_sum  = {1'b0, addr} + BLEN_A;
    assign last_word = ({1'b0, rptr} == (cnt - ONE_L));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        pop            = 1'b0;
        idle_tick      = 1'b0;
        fifo_rd_enable = 1'b0;
        cmd_valid      = 1'b0;
        cmd_addr       = '0;
        cmd_len        = '0;
        wr_data        = '0;
        busy           = (state != IDLE);
        case (state)
            IDLE: begin
                if (enable) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                // Popping is gated by enable so nothing leaves the FIFO once a stop is seen
                pop       = enable && !fifo_empty && (cnt < BLEN_L);
                idle_tick = fifo_empty && (cnt != '0);
                if (pop && (cnt == LAST_SLOT)) begin
                    state_next = CMD;
                end else if (idle_tick && (idle_cnt == FLUSH_LAST)) begin
                    state_next = CMD;
                end else if (!enable) begin
                    state_next = (cnt != '0) ? CMD : IDLE;
                end
            end
            CMD: begin
                cmd_valid = 1'b1;
                cmd_addr  = addr;
                cmd_len   = cnt;
                if (cmd_ready) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                wr_data = buf_rd_data;
                if (wr_data_req && last_word) begin
                    state_next = enable ? FILL : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        fifo_rd_enable = pop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr     <= '0;
            cnt      <= '0;
            rptr     <= '0;
            idle_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        addr <= base_addr;
                        cnt  <= '0;
                    end
                end
                FILL: begin
                    if (pop) begin
                        cnt      <= cnt + ONE_L;
                        idle_cnt <= '0;
                    end else if (idle_tick) begin
                        idle_cnt <= idle_cnt + IW'(1);
                    end else begin
                        idle_cnt <= '0;
                    end
                    if (state_next != FILL) begin
                        idle_cnt <= '0;
                    end
                end
                CMD: begin
                    if (cmd_ready) begin
                        rptr <= '0;
                    end
                end
                DATA: begin
                    if (wr_data_req) begin
                        rptr <= rptr + IXW'(1);
                        // Partial bursts still consume a whole BLEN slot of the region
                        if (last_word) begin
                            cnt  <= '0;
                            addr <= (addr_sum >= {1'b0, limit_addr}) ? base_addr
                                                                     : addr_sum[AWIDTH-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    burst_buffer #(
        .DWIDTH(DWIDTH),
        .BLEN  (BLEN)
    ) u_buffer (
        .clk    (clk),
        .wr_en  (pop),
        .wr_idx (cnt[IXW-1:0]),
        .wr_data(fifo_rd_data),
        .rd_idx (rptr),
        .rd_data(buf_rd_data)
    );

endmodule

// File: tb/tb_fifo_burst_drain.sv
// Self-checking bench for fifo_burst_drain: directed scenarios plus a
// randomized run scored against a word-stream / burst-accounting model.
module tb_fifo_burst_drain;

    localparam int DW = 16;
    localparam int AW = 22;
    localparam int BL = 8;
    localparam int FC = 16;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] limit_addr;
    logic [DW-1:0] fifo_rd_data;
    logic          fifo_empty;
    logic          fifo_rd_enable;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic [DW-1:0] wr_data;
    logic          wr_data_req;
    logic          busy;

    fifo_burst_drain #(
        .DWIDTH      (DW),
        .AWIDTH      (AW),
        .BLEN        (BL),
        .FLUSH_CYCLES(FC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .base_addr     (base_addr),
        .limit_addr    (limit_addr),
        .fifo_rd_data  (fifo_rd_data),
        .fifo_empty    (fifo_empty),
        .fifo_rd_enable(fifo_rd_enable),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_addr      (cmd_addr),
        .cmd_len       (cmd_len),
        .wr_data       (wr_data),
        .wr_data_req   (wr_data_req),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_data_q[$];
    logic [AW-1:0] cmd_addr_log[$];
    logic [AW-1:0] exp_addr;
    logic [AW-1:0] held_addr;
    logic [LW-1:0] held_len;
    int  pending, beats_left, pop_count, beat_count, n_cmds;
    int  cyc = 0, first_pop_cyc, last_pop_cyc, cmd_rise_cyc;
    bit  pop_now, hold_pending, cmd_valid_d;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic void drive_fifo();
        fifo_empty   = (fifo_q.size() == 0);
        fifo_rd_data = fifo_empty ? '0 : fifo_q[0];
    endfunction

    task automatic applyStimulus(input logic en, input logic ready, input logic req);
        enable      = en;
        cmd_ready   = ready;
        wr_data_req = req;
    endtask

    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
        return (int'(a) + BL >= int'(limit_addr)) ? base_addr : a + AW'(BL);
    endfunction

    function automatic void clear_model();
        exp_data_q.delete();
        cmd_addr_log.delete();
        exp_addr     = base_addr;
        pending      = 0;
        beats_left   = 0;
        pop_count    = 0;
        beat_count   = 0;
        n_cmds       = 0;
        hold_pending = 0;
        cmd_valid_d  = 0;
        pop_now      = 0;
    endfunction

    // Observe at the falling edge, then let the FIFO model react to the pop
    task automatic tick();
        @(negedge clk);
        cyc++;
        pop_now = 0;
        if (rst_n) begin
            if (fifo_rd_enable) begin
                checkOutput("pop_while_empty", fifo_empty, 1'b0);
                if (fifo_q.size() != 0) begin
                    exp_data_q.push_back(fifo_q[0]);
                    pop_now = 1;
                end
                if (pop_count == 0) first_pop_cyc = cyc;
                pop_count++;
                pending++;
                last_pop_cyc = cyc;
            end
            if (cmd_valid && !cmd_valid_d) cmd_rise_cyc = cyc;
            if (hold_pending) begin
                checkOutput("cmd_hold_valid", cmd_valid, 1'b1);
                checkOutput("cmd_hold_addr", cmd_addr, held_addr);
                checkOutput("cmd_hold_len", cmd_len, held_len);
            end
            hold_pending = cmd_valid && !cmd_ready;
            held_addr    = cmd_addr;
            held_len     = cmd_len;
            if (beats_left > 0 && wr_data_req && exp_data_q.size() != 0) begin
                checkOutput("wr_data", wr_data, exp_data_q.pop_front());
                beats_left--;
                beat_count++;
                if (beats_left == 0) exp_addr = next_addr(exp_addr);
            end
            if (cmd_valid && cmd_ready) begin
                checkOutput("cmd_addr", cmd_addr, exp_addr);
                checkOutput("cmd_len", cmd_len, pending);
                cmd_addr_log.push_back(cmd_addr);
                beats_left = pending;
                pending    = 0;
                n_cmds++;
            end
            cmd_valid_d = cmd_valid;
        end
        @(posedge clk);
        #1;
        if (pop_now) void'(fifo_q.pop_front());
        drive_fifo();
    endtask

    task automatic pulse_reset();
        applyStimulus(1'b0, 1'b0, 1'b0);
        fifo_q.delete();
        drive_fifo();
        rst_n = 1'b0;
        clear_model();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_cmd_valid(input int bound);
        for (int i = 0; i < bound && !cmd_valid; i++) tick();
        checkOutput("cmd_valid_timeout", cmd_valid, 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, "_rd_en"}, fifo_rd_enable, 1'b0);
        checkOutput({tag, "_cmd_valid"}, cmd_valid, 1'b0);
        checkOutput({tag, "_cmd_addr"}, cmd_addr, 0);
        checkOutput({tag, "_cmd_len"}, cmd_len, 0);
        checkOutput({tag, "_wr_data"}, wr_data, 0);
        checkOutput({tag, "_busy"}, busy, 1'b0);
    endtask

    logic [AW-1:0] wrap_exp[5];

    initial begin
        wrap_exp   = '{22'h100, 22'h108, 22'h110, 22'h118, 22'h100};
        base_addr  = 22'h100;
        limit_addr = 22'h120;
        rst_n      = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        clear_model();

        // reset held with a non-empty FIFO and enable high
        fifo_q.push_back(16'h1234);
        drive_fifo();
        for (int i = 0; i < 3; i++) begin
            tick();
            check_all_zero("reset");
        end

        // full burst: 8 back-to-back pops, command stalled 5 cycles, paced data
        pulse_reset();
        for (int i = 0; i < BL; i++) fifo_q.push_back(DW'(32'hA0 + i));
        drive_fifo();
        applyStimulus(1'b1, 1'b0, 1'b0);
        wait_cmd_valid(40);
        repeat (5) tick();
        checkOutput("full_pops", pop_count, BL);
        checkOutput("full_pop_span", last_pop_cyc - first_pop_cyc, BL - 1);
        checkOutput("full_cmd_latency", cmd_rise_cyc - last_pop_cyc, 1);
        checkOutput("full_cmd_valid", cmd_valid, 1'b1);
        checkOutput("full_cmd_addr", cmd_addr, 22'h100);
        checkOutput("full_cmd_len", cmd_len, BL);
        applyStimulus(1'b1, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 40 && beats_left > 0; i++) begin
            applyStimulus(1'b1, 1'b0, (i % 2) == 0);
            tick();
        end
        checkOutput("full_beats", beat_count, BL);
        checkOutput("full_after_busy", busy, 1'b1);
        checkOutput("full_after_cmd_valid", cmd_valid, 1'b0);

        // wrap: 40 continuous words give five bursts around the region
        pulse_reset();
        for (int i = 0; i < 40; i++) fifo_q.push_back(DW'($urandom));
        drive_fifo();
        applyStimulus(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 400 && !(n_cmds == 5 && beats_left == 0); i++) tick();
        checkOutput("wrap_beats", beat_count, 40);
        for (int k = 0; k < 5; k++)
            checkOutput($sformatf("wrap_addr%0d", k), cmd_addr_log[k], wrap_exp[k]);

        // partial flush after FLUSH_CYCLES empty cycles
        pulse_reset();
        for (int i = 0; i < 3; i++) fifo_q.push_back(DW'(32'hC0 + i));
        drive_fifo();
        applyStimulus(1'b1, 1'b0, 1'b0);
        wait_cmd_valid(60);
        tick();
        checkOutput("flush_latency", cmd_rise_cyc - last_pop_cyc, FC + 1);
        checkOutput("flush_cmd_len", cmd_len, 3);
        checkOutput("flush_cmd_addr", cmd_addr, 22'h100);
        applyStimulus(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 30 && !(n_cmds == 1 && beats_left == 0); i++) tick();
        for (int i = 0; i < BL; i++) fifo_q.push_back(DW'(32'hD0 + i));
        drive_fifo();
        for (int i = 0; i < 60 && n_cmds < 2; i++) tick();
        checkOutput("flush_next_addr", cmd_addr_log[1], 22'h108);

        // enable dropped after 5 pops: flush immediately, then stay idle
        pulse_reset();
        for (int i = 0; i < 10; i++) fifo_q.push_back(DW'(32'hE0 + i));
        drive_fifo();
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 40 && pop_count < 5; i++) tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("drop_no_pop", pop_count, 5);
        checkOutput("drop_cmd_valid", cmd_valid, 1'b1);
        checkOutput("drop_cmd_len", cmd_len, 5);
        applyStimulus(1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20 && beats_left > 0; i++) tick();
        checkOutput("drop_beats", beat_count, 5);
        checkOutput("drop_busy", busy, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            #1;
            checkOutput("drop_no_rd_en", fifo_rd_enable, 1'b0);
            tick();
        end

        // reset in the middle of a data phase
        pulse_reset();
        for (int i = 0; i < BL; i++) fifo_q.push_back(DW'(32'h5A00 + i));
        drive_fifo();
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 30 && beats_left == 0; i++) tick();
        applyStimulus(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 20 && beat_count < 3; i++) tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        clear_model();
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < BL; i++) fifo_q.push_back(DW'(32'h7700 + i));
        drive_fifo();
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("midreset_idle_valid", cmd_valid, 1'b0);
            checkOutput("midreset_idle_busy", busy, 1'b0);
        end
        checkOutput("midreset_no_pops", pop_count, 0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 40 && n_cmds < 1; i++) tick();
        checkOutput("rearm_addr", cmd_addr_log[0], 22'h100);
        for (int i = 0; i < 20 && beats_left > 0; i++) tick();

        // randomized traffic with bursty arrivals and random back-pressure
        base_addr  = 22'h40;
        limit_addr = 22'h80;
        pulse_reset();
        begin
            int gap = 0;
            for (int c = 0; c < 2500; c++) begin
                if (gap > 0) gap--;
                else if ($urandom_range(99) < 3) gap = $urandom_range(30, 10);
                else if ($urandom_range(99) < 60 && fifo_q.size() < 32)
                    fifo_q.push_back(DW'($urandom));
                drive_fifo();
                applyStimulus(1'b1, $urandom_range(2) != 0, $urandom_range(3) != 0);
                tick();
            end
        end
        for (int i = 0; i < 600 && fifo_q.size() != 0; i++) begin
            applyStimulus(1'b1, $urandom_range(2) != 0, $urandom_range(3) != 0);
            tick();
        end
        for (int i = 0; i < 300 && (busy || beats_left != 0 || pending != 0); i++) begin
            applyStimulus(1'b0, $urandom_range(2) != 0, $urandom_range(3) != 0);
            tick();
        end
        checkOutput("drain_busy", busy, 1'b0);
        checkOutput("drain_words_left", exp_data_q.size(), 0);
        checkOutput("drain_pending", pending, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
